dma_read_fifo: RTL
==================

Name: dma_read_fifo

Overview:
- Data FIFO between the DMA memory-read stage and the memory-write stage.
- Captures read data returned by the read master, one word per accepted read. It generates the lookahead full flag p1_fifo_full that gates the read-state machine, and presents show-ahead data to the write stage.
- Single clock domain.
- Qualified by the global clk_en.

Parameters:
- DATA_WIDTH, 32, width of each data word.
- ADDR_WIDTH, 5, log2 of the depth; DEPTH = 2**ADDR_WIDTH (32). ADDR_WIDTH must be at least 2.
- FULL_MARGIN, 1, number of free slots still remaining when p1_fifo_full asserts; legal range is 0 to DEPTH-1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clk_en  in  1  global enable; when low, no state changes at all.
- clear  in  1  synchronous flush, e.g. at DMA go or at abort.
- fifo_wr  in  1  push strobe; driven by the read stage's inc_read or readdatavalid.
- fifo_wrdata  in  DATA_WIDTH  push data.
- fifo_rd  in  1  pop strobe from the write stage.
- fifo_rddata  out  DATA_WIDTH  head entry (show-ahead); forced to 0 when empty.
- fifo_empty  out  1  registered; high when count==0.
- fifo_full  out  1  registered; high when count==DEPTH.
- p1_fifo_full  out  1  combinational lookahead; high when (count_next + FULL_MARGIN) >= DEPTH.
- fifo_count  out  ADDR_WIDTH+1  number of entries held, 0 to DEPTH.
- overflow  out  1  sticky: a push was dropped.
- underflow  out  1  sticky: a pop was ignored.

Behaviour:
- Reset values (reset_n low, asynchronous):
  - Pointers, fifo_count, overflow and underflow are 0.
  - fifo_empty is 1 and fifo_full is 0.
  - p1_fifo_full is 0.
  - fifo_rddata is 0.
  - Storage array is not reset.
- Register updates: every register updates only on a rising edge with clk_en high.
- Priority: clear > pop/push.
  - A clear cycle zeroes the pointers, count and sticky flags, sets empty, and discards any same-cycle push or pop.
- Accept rules, evaluated on the registered state at the start of the cycle:
  - rd_ok = fifo_rd & ~fifo_empty.
  - wr_ok = fifo_wr & (~fifo_full | rd_ok).
  - Push and pop in the same cycle while full are both accepted; count stays DEPTH.
  - Push and pop in the same cycle while empty: only the push is accepted (no fall-through). The pop is ignored and sets underflow.
- Drop and ignore rules:
  - fifo_wr & ~wr_ok drops the word, leaves the state unchanged and sets overflow.
  - fifo_rd & fifo_empty sets underflow.
- Write path: wr_ok writes mem[wr_ptr] <= fifo_wrdata and wr_ptr increments modulo DEPTH, wrapping from DEPTH-1 to 0.
- Read path: rd_ok increments rd_ptr modulo DEPTH.
- Output data: fifo_rddata = mem[rd_ptr] when ~fifo_empty, else 0. The next entry is visible the cycle after a pop.
- Count:
  - count_next = count + wr_ok - rd_ok.
  - When clear is high, count_next is 0.
  - When clk_en is low, count_next equals count.
  - fifo_count, fifo_empty and fifo_full are registered from count_next.
- Lookahead flag: p1_fifo_full is computed from count_next, so the read stage sees "full next cycle" in time for its registered read_select.
  - With FULL_MARGIN=1, it asserts when count_next is 31 or more.
- Latency:
  - Pushed data is visible on fifo_rddata one cycle after the push edge.
  - fifo_empty deasserts on that same edge.
- No combinational path from fifo_rd or fifo_wr to fifo_empty, fifo_full or fifo_count. A combinational path to p1_fifo_full is intentional.
- Reset asserted mid-operation: returns to the reset values immediately, without waiting for clk; the contents are lost.

Test Plan:
- Reset, then 4 pushes (0x11, 0x22, 0x33, 0x44) with no pops:
  - fifo_empty falls 1 cycle after the first push.
  - fifo_rddata=0x11 and fifo_count=4.
  - Then 4 pops return 0x11, 0x22, 0x33, 0x44 in order, and fifo_empty=1 after the last pop.
- Fill to 32 entries with DEPTH=32, FULL_MARGIN=1:
  - p1_fifo_full is high in the cycle whose push makes count 31.
  - fifo_full=1 at count 32.
  - A 33rd push is dropped, overflow=1 and count stays 32.
- Full FIFO with simultaneous push 0xAA and pop:
  - Both accepted; count stays 32 and the head advances.
  - 0xAA emerges after 31 further pops.
- Empty FIFO with simultaneous push 0x55 and pop:
  - Count becomes 1, underflow=1, and fifo_rddata=0x55 on the next cycle.
- 100 push/pop pairs on a half-full FIFO: pointers wrap cleanly and the data order is preserved.
- clear asserted with count=10 together with a push:
  - Next cycle: count=0, empty=1, overflow=0.
  - With clk_en low, a push, a pop or clear has no effect.
- Reset pulse mid-stream: outputs go to the reset values asynchronously.

Source files
------------

// File: rtl/dma_read_fifo.sv
// dma_read_fifo: show-ahead data FIFO between the DMA read and write stages.
// Raises p1_fifo_full one cycle early so the read stage can stop issuing in time.
//
// Ports:
//   clk, reset_n      clock, async active-low reset
//   clk_en            global enable; low freezes all state
//   clear             synchronous flush (wins over push/pop)
//   fifo_wr/wrdata    push strobe and data from the read stage
//   fifo_rd           pop strobe from the write stage
//   fifo_rddata       head entry, 0 when empty
//   fifo_empty/full   registered flags
//   p1_fifo_full      lookahead full, from next-cycle count
//   fifo_count        entries held, 0..DEPTH
//   overflow          sticky: push dropped
//   underflow         sticky: pop ignored
module dma_read_fifo #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 5,
   parameter int FULL_MARGIN = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  clk_en,
   input  logic                  clear,
   input  logic                  fifo_wr,
   input  logic [DATA_WIDTH-1:0] fifo_wrdata,
   input  logic                  fifo_rd,
   output logic [DATA_WIDTH-1:0] fifo_rddata,
   output logic                  fifo_empty,
   output logic                  fifo_full,
   output logic                  p1_fifo_full,
   output logic [ADDR_WIDTH:0]   fifo_count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE =
      {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH:0] CNT_ONE =
      {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH:0] CNT_FULL =
      {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH+1:0] MARGIN =
      (ADDR_WIDTH+2)'(FULL_MARGIN);
   localparam logic [ADDR_WIDTH+1:0] DEPTH_W =
      {2'b01, {ADDR_WIDTH{1'b0}}};

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic                  empty_q, empty_d;
   logic                  full_q, full_d;
   logic                  ovf_q, ovf_d;
   logic                  unf_q, unf_d;
   logic                  rd_ok, wr_ok, mem_we;

   // A push into a full FIFO is only legal when a pop frees the slot.
   assign rd_ok  = fifo_rd & ~empty_q;
   assign wr_ok  = fifo_wr & (~full_q | rd_ok);
   assign mem_we = clk_en & ~clear & wr_ok;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      unf_d    = unf_q;
      if (clk_en) begin
         if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
         end else begin
            if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (rd_ok) rd_ptr_d = rd_ptr_q + PTR_ONE;
            unique case ({wr_ok, rd_ok})
               2'b10:   count_d = count_q + CNT_ONE;
               2'b01:   count_d = count_q - CNT_ONE;
               default: count_d = count_q;
            endcase
            if (fifo_wr & ~wr_ok) ovf_d = 1'b1;
            if (fifo_rd & empty_q) unf_d = 1'b1;
         end
      end
      empty_d = (count_d == '0);
      full_d  = (count_d == CNT_FULL);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         empty_q  <= empty_d;
         full_q   <= full_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[wr_ptr_q] <= fifo_wrdata;
   end

   // Gated by reset_n so the flag reads 0 while reset is held,
   // whatever the margin and inputs.
   assign p1_fifo_full = reset_n &
      (({1'b0, count_d} + MARGIN) >= DEPTH_W);

   assign fifo_rddata = empty_q ? '0 : mem_q[rd_ptr_q];
   assign fifo_empty  = empty_q;
   assign fifo_full   = full_q;
   assign fifo_count  = count_q;
   assign overflow    = ovf_q;
   assign underflow   = unf_q;

endmodule
